clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Downstream checker for the divider outputs. Consumes a divided clock (e.g. the divide-by-3 clk_out) as a data signal sampled in the source clk domain.
- Measures period, high time and low time in clk cycles, and compares the period against an expected ratio.
- Reports lock, period errors, duty errors and stuck-clock conditions.
- Intended for on-chip self-check of the clock-divider family and as a reusable bench monitor.

Parameters:
CNT_W, 8, width of all cycle counters and measurement outputs.
SYNC_STAGES, 2, synchronizer flops on div_in (minimum 2).
LOCK_CNT, 4, consecutive matching periods required to assert locked.

Ports:
clk  input  1  source clock; also the clock that drives the monitored divider.
rst  input  1  asynchronous, active-high reset.
en  input  1  monitor enable; 0 forces IDLE.
div_in  input  1  divided clock under test.
exp_period  input  CNT_W  expected period in clk cycles; valid range 2..2^CNT_W/2-1.
clr_err  input  1  synchronous clear of sticky error flags.
period  output  CNT_W  last measured period.
high_cnt  output  CNT_W  last measured high time.
low_cnt  output  CNT_W  last measured low time.
meas_valid  output  1  one-cycle pulse when period/high_cnt/low_cnt update.
locked  output  1  LOCK_CNT consecutive periods equal to exp_period.
period_err  output  1  sticky flag: a measured period differed from exp_period.
duty_err  output  1  sticky flag: |high_cnt - low_cnt| > 1.
stuck  output  1  no rising edge seen within 2*exp_period cycles.

Behaviour:
- Reset: rst=1 asynchronously clears everything.
  - All outputs go to 0.
  - Synchronizer, edge register, counters and lock counter go to 0.
  - FSM goes to IDLE.
- Edge detection:
  - s = div_in after SYNC_STAGES flops; s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Total detection latency from a div_in change is SYNC_STAGES+1 cycles.
- Cycle counter cnt (CNT_W bits):
  - Cleared to 0 on rise.
  - Otherwise increments by 1, saturating at all-ones.
- FSM states: IDLE, ACQ, MEAS, STUCK.
  - IDLE: counters held at 0, locked=0. Moves to ACQ when en=1.
  - ACQ: waits for the first rise; no measurement is produced. On rise, moves to MEAS.
  - MEAS, on fall: high_lat <= cnt+1.
  - MEAS, on rise (completes one period):
    - period <= cnt+1; high_cnt <= high_lat; low_cnt <= cnt+1-high_lat.
    - meas_valid pulses in the same cycle the registers update (visible the cycle after rise).
  - MEAS, no rise by the cycle cnt reaches 2*exp_period: go to STUCK; set stuck=1, locked=0, lock counter=0.
  - STUCK: on rise, clear stuck, restart cnt, return to MEAS. That first partial period is discarded: no meas_valid.
  - en=0 in any state returns to IDLE next cycle. Sticky flags and last measurements are held.
- Compare, at each completed period:
  - Period mismatch (period != exp_period): set period_err and clear the lock counter.
  - Period match: the lock counter increments, saturating at LOCK_CNT.
  - locked = (lock counter == LOCK_CNT), registered.
  - duty_err is set when |high - low| > 1. Tolerance of 1 accommodates odd ratios with 50% duty generated on both clock edges.
- Sticky flags: clr_err clears period_err and duty_err. If clr_err and a new error occur in the same cycle, set wins.
- exp_period change mid-measurement takes effect at the next compare. No retroactive check.
- A rise and a fall in the same cycle is impossible after synchronization (single-bit s); no handling is required.
- Arithmetic: all unsigned, CNT_W bits. 2*exp_period is computed at CNT_W+1 bits.

Decomposition:
- Shared package clk_div_pkg:
  - FSM state encoding (IDLE=0, ACQ=1, MEAS=2, STUCK=3).
  - Default CNT_W.
  - LOCK_CNT default.
- One sub-module: clk_sync_edge, the SYNC_STAGES synchronizer plus rise/fall pulse generator. It is reused by the other divider-family checkers.

Test Plan:
- Divide-by-3 source (clk_div_3, 50% duty, clk period 10 ns), exp_period=3, en=1 after reset:
  - meas_valid every 3 cycles with period=3, {high_cnt,low_cnt} = {1,2} or {2,1}.
  - locked=1 after the 4th matching period; duty_err=0.
- div_in as a divide-by-4 square wave, exp_period=3:
  - period_err=1 at the first compare; locked stays 0.
  - Switch exp_period to 4: locked=1 after 4 periods; period_err remains 1 until clr_err.
- Divide-by-4 with 1-high/3-low duty, exp_period=4 -> period=4, high_cnt=1, low_cnt=3, duty_err=1.
- Stop div_in low with exp_period=3:
  - stuck=1 six cycles after the last rise; locked=0.
  - Resume div_in: stuck clears on the first rise; the next meas_valid occurs only after one full period.
- Assert rst for one cycle while locked=1 mid-period: all outputs return to 0 immediately (asynchronously). After release, re-acquisition needs ACQ plus 4 periods to relock.
- Hold clr_err=1 while a period mismatch is detected -> period_err reads 1 (set wins). Release clr_err on a matching stream, then pulse clr_err -> period_err=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider checker family.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_MEAS  = 2'd2,
        ST_STUCK = 2'd3
    } mon_state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int LOCK_CNT_DEF    = 4;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_sync_edge.sv
// Multi-flop synchronizer for a divided clock sampled as data, plus rise/fall pulses.
module clk_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic                   s_s;

    assign s_s = sync_r[SYNC_STAGES-1];

    // synchronizer chain and one-cycle delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            s_d_r  <= s_s;
        end
    end

    assign rise = s_s & ~s_d_r;
    assign fall = ~s_s & s_d_r;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high/low of a divided clock in source-clock cycles and
// reports lock, period/duty errors and stuck-clock conditions.
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             period_err,
    output logic             duty_err,
    output logic             stuck
);

    localparam int LK_W = $clog2(LOCK_CNT + 1);

    mon_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] high_lat_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_cnt_r;
    logic [CNT_W-1:0] low_cnt_r;
    logic [LK_W-1:0]  lock_cnt_r;
    logic             meas_valid_r;
    logic             locked_r;
    logic             period_err_r;
    logic             duty_err_r;
    logic             stuck_r;

    logic             rise_s;
    logic             fall_s;
    logic [CNT_W-1:0] cnt_p1_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] low_next_s;
    logic [CNT_W:0]   cnt_p1_w_s;
    logic [CNT_W:0]   stuck_lim_s;
    logic [LK_W-1:0]  lock_next_s;
    logic             meas_evt_s;
    logic             per_miss_s;
    logic             duty_bad_s;
    logic             stuck_hit_s;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    clk_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (div_in),
        .rise (rise_s),
        .fall (fall_s)
    );

    // measurement arithmetic, stuck threshold and next lock count
    always_comb begin
        cnt_p1_s    = cnt_r + CNT_W'(1'b1);
        cnt_p1_w_s  = {1'b0, cnt_r} + (CNT_W+1)'(1'b1);
        stuck_lim_s = {exp_period, 1'b0};
        low_next_s  = cnt_p1_s - high_lat_r;
        meas_evt_s  = en && (state_r == ST_MEAS) && rise_s;
        per_miss_s  = (cnt_p1_s != exp_period);
        duty_bad_s  = (abs_diff(high_lat_r, low_next_s) > CNT_W'(1'b1));
        // threshold is checked on the value cnt is about to take
        stuck_hit_s = !rise_s && (cnt_p1_w_s >= stuck_lim_s);
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_p1_s;
        end
        if (per_miss_s) begin
            lock_next_s = {LK_W{1'b0}};
        end else if (lock_cnt_r == LK_W'(LOCK_CNT)) begin
            lock_next_s = lock_cnt_r;
        end else begin
            lock_next_s = lock_cnt_r + LK_W'(1'b1);
        end
    end

    // sticky error flags; a new error wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_err_r <= 1'b0;
            duty_err_r   <= 1'b0;
        end else begin
            if (meas_evt_s && per_miss_s) begin
                period_err_r <= 1'b1;
            end else if (clr_err) begin
                period_err_r <= 1'b0;
            end
            if (meas_evt_s && duty_bad_s) begin
                duty_err_r <= 1'b1;
            end else if (clr_err) begin
                duty_err_r <= 1'b0;
            end
        end
    end

    // monitor FSM, cycle counter, measurement and lock registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            high_lat_r   <= {CNT_W{1'b0}};
            period_r     <= {CNT_W{1'b0}};
            high_cnt_r   <= {CNT_W{1'b0}};
            low_cnt_r    <= {CNT_W{1'b0}};
            lock_cnt_r   <= {LK_W{1'b0}};
            meas_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            stuck_r      <= 1'b0;
        end else begin
            meas_valid_r <= 1'b0;
            if (!en) begin
                state_r    <= ST_IDLE;
                cnt_r      <= {CNT_W{1'b0}};
                lock_cnt_r <= {LK_W{1'b0}};
                locked_r   <= 1'b0;
                stuck_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_ACQ;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                    ST_ACQ: begin
                        if (rise_s) begin
                            state_r <= ST_MEAS;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    ST_MEAS: begin
                        if (rise_s) begin
                            cnt_r        <= {CNT_W{1'b0}};
                            period_r     <= cnt_p1_s;
                            high_cnt_r   <= high_lat_r;
                            low_cnt_r    <= low_next_s;
                            meas_valid_r <= 1'b1;
                            lock_cnt_r   <= lock_next_s;
                            locked_r     <= (lock_next_s == LK_W'(LOCK_CNT));
                        end else begin
                            cnt_r <= cnt_inc_s;
                            if (fall_s) begin
                                high_lat_r <= cnt_p1_s;
                            end
                            if (stuck_hit_s) begin
                                state_r    <= ST_STUCK;
                                stuck_r    <= 1'b1;
                                locked_r   <= 1'b0;
                                lock_cnt_r <= {LK_W{1'b0}};
                            end
                        end
                    end
                    ST_STUCK: begin
                        // the partial period ending at this rise is not reported
                        if (rise_s) begin
                            state_r <= ST_MEAS;
                            stuck_r <= 1'b0;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign period     = period_r;
    assign high_cnt   = high_cnt_r;
    assign low_cnt    = low_cnt_r;
    assign meas_valid = meas_valid_r;
    assign locked     = locked_r;
    assign period_err = period_err_r;
    assign duty_err   = duty_err_r;
    assign stuck      = stuck_r;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized self-checking bench for clk_div_monitor against an edge-time reference model.
module tb_clk_div_monitor;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_CNT    = 4;
    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_MEAS  = 2;
    localparam int M_STUCK = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_in;
    logic [CNT_W-1:0] exp_period;
    logic             clr_err;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             meas_valid;
    logic             locked;
    logic             period_err;
    logic             duty_err;
    logic             stuck;

    clk_div_monitor #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .exp_period (exp_period),
        .clr_err    (clr_err),
        .period     (period),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .meas_valid (meas_valid),
        .locked     (locked),
        .period_err (period_err),
        .duty_err   (duty_err),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int edge_no = 0;
    int set_hits = 0;
    bit clr_rand = 1'b0;
    bit chk_set_wins = 1'b0;

    // reference model: event times measured in clock edges
    int m_mode, m_rlast, m_h, m_run;
    bit hist[SYNC_STAGES+2];
    int e_period, e_high, e_low, e_mv, e_locked, e_perr, e_derr, e_stuck;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, want, edge_no, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_rlast = 0; m_h = 0; m_run = 0;
        for (int k = 0; k < SYNC_STAGES + 2; k++) hist[k] = 1'b0;
        e_period = 0; e_high = 0; e_low = 0; e_mv = 0;
        e_locked = 0; e_perr = 0; e_derr = 0; e_stuck = 0;
    endtask

    task automatic model_edge();
        int p, d, xp;
        bit rise, fall, per_set, duty_set;
        if (rst) begin
            model_reset();
            return;
        end
        edge_no++;
        for (int k = SYNC_STAGES + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = div_in;
        // div_in seen SYNC_STAGES edges late, compared with one edge earlier
        rise = hist[SYNC_STAGES] && !hist[SYNC_STAGES+1];
        fall = !hist[SYNC_STAGES] && hist[SYNC_STAGES+1];
        xp = int'(exp_period);
        per_set = 1'b0; duty_set = 1'b0; e_mv = 0;
        if (!en) begin
            m_mode = M_IDLE; m_run = 0; e_locked = 0; e_stuck = 0;
        end else begin
            case (m_mode)
                M_IDLE: m_mode = M_ACQ;
                M_ACQ: if (rise) begin m_mode = M_MEAS; m_rlast = edge_no; end
                M_MEAS: begin
                    if (rise) begin
                        p = edge_no - m_rlast;
                        e_period = p; e_high = m_h; e_low = p - m_h; e_mv = 1;
                        if (p != xp) begin per_set = 1'b1; m_run = 0; end
                        else if (m_run < LOCK_CNT) m_run++;
                        e_locked = (m_run == LOCK_CNT) ? 1 : 0;
                        d = m_h - (p - m_h);
                        if (d > 1 || d < -1) duty_set = 1'b1;
                        m_rlast = edge_no;
                    end else begin
                        if (fall) m_h = edge_no - m_rlast;
                        if (edge_no - m_rlast >= 2 * xp) begin
                            m_mode = M_STUCK; e_stuck = 1; e_locked = 0; m_run = 0;
                        end
                    end
                end
                default: if (rise) begin m_mode = M_MEAS; e_stuck = 0; m_rlast = edge_no; end
            endcase
        end
        if (per_set) e_perr = 1; else if (clr_err) e_perr = 0;
        if (duty_set) e_derr = 1; else if (clr_err) e_derr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_val("period", 32'(period), e_period);
        check_val("high_cnt", 32'(high_cnt), e_high);
        check_val("low_cnt", 32'(low_cnt), e_low);
        check_val("meas_valid", 32'(meas_valid), e_mv);
        check_val("locked", 32'(locked), e_locked);
        check_val("period_err", 32'(period_err), e_perr);
        check_val("duty_err", 32'(duty_err), e_derr);
        check_val("stuck", 32'(stuck), e_stuck);
        if (chk_set_wins && meas_valid === 1'b1 && period !== exp_period) begin
            set_hits++;
            check_val("set_wins", 32'(period_err), 32'd1);
        end
    endtask

    task automatic drive_cycle(input bit lvl);
        div_in = lvl;
        if (clr_rand) clr_err = ($urandom_range(0, 7) == 0);
        tick();
    endtask

    task automatic drive_wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi; j++) drive_cycle(1'b1);
            for (int j = 0; j < lo; j++) drive_cycle(1'b0);
        end
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_period"}, 32'(period), 32'd0);
        check_val({pfx, "_high"}, 32'(high_cnt), 32'd0);
        check_val({pfx, "_low"}, 32'(low_cnt), 32'd0);
        check_val({pfx, "_mv"}, 32'(meas_valid), 32'd0);
        check_val({pfx, "_locked"}, 32'(locked), 32'd0);
        check_val({pfx, "_perr"}, 32'(period_err), 32'd0);
        check_val({pfx, "_derr"}, 32'(duty_err), 32'd0);
        check_val({pfx, "_stuck"}, 32'(stuck), 32'd0);
    endtask

    initial begin
        int p, h, hold;
        rst = 1'b0; en = 1'b0; div_in = 1'b0; clr_err = 1'b0; exp_period = 8'd3;
        model_reset();
        #2 rst = 1'b1;
        #1 check_zero("reset");
        tick(); tick();
        rst = 1'b0;
        en = 1'b1;

        // divide-by-3 stream, expected 3
        drive_wave(2, 1, 10);
        check_val("div3_locked", 32'(locked), 32'd1);
        check_val("div3_period", 32'(period), 32'd3);
        check_val("div3_duty_err", 32'(duty_err), 32'd0);

        // divide-by-4 against expected 3, then retarget to 4
        drive_wave(2, 2, 3);
        check_val("div4_perr", 32'(period_err), 32'd1);
        check_val("div4_unlocked", 32'(locked), 32'd0);
        exp_period = 8'd4;
        drive_wave(2, 2, 6);
        check_val("div4_relock", 32'(locked), 32'd1);
        check_val("div4_perr_sticky", 32'(period_err), 32'd1);
        clr_err = 1'b1;
        drive_wave(2, 2, 1);
        clr_err = 1'b0;
        check_val("div4_perr_cleared", 32'(period_err), 32'd0);

        // 1-high/3-low duty
        drive_wave(1, 3, 4);
        check_val("duty_period", 32'(period), 32'd4);
        check_val("duty_high", 32'(high_cnt), 32'd1);
        check_val("duty_low", 32'(low_cnt), 32'd3);
        check_val("duty_err_set", 32'(duty_err), 32'd1);

        // stop the clock low, then resume
        exp_period = 8'd3;
        drive_wave(2, 1, 6);
        for (int i = 0; i < 12; i++) drive_cycle(1'b0);
        check_val("stuck_set", 32'(stuck), 32'd1);
        check_val("stuck_unlocked", 32'(locked), 32'd0);
        drive_wave(2, 1, 4);
        check_val("stuck_cleared", 32'(stuck), 32'd0);

        // disable briefly, then relock
        en = 1'b0;
        drive_wave(2, 1, 1);
        en = 1'b1;
        drive_wave(2, 1, 8);
        check_val("en_relock", 32'(locked), 32'd1);

        // asynchronous reset mid-period while locked
        div_in = 1'b1;
        tick();
        #3 rst = 1'b1;
        #1 check_zero("async_rst");
        tick();
        rst = 1'b0;
        drive_wave(2, 1, 7);
        check_val("rst_relock", 32'(locked), 32'd1);

        // clear held during a mismatch: set wins
        clr_err = 1'b1;
        chk_set_wins = 1'b1;
        drive_wave(2, 2, 3);
        chk_set_wins = 1'b0;
        check_val("set_wins_seen", 32'(set_hits > 0), 32'd1);
        clr_err = 1'b0;
        drive_wave(2, 1, 3);
        clr_err = 1'b1;
        drive_wave(2, 1, 1);
        clr_err = 1'b0;
        check_val("clr_after_match", 32'(period_err), 32'd0);

        // randomized segments
        clr_rand = 1'b1;
        for (int s = 0; s < 40; s++) begin
            p = $urandom_range(2, 12);
            h = $urandom_range(1, p - 1);
            if ($urandom_range(0, 2) == 0) exp_period = 8'($urandom_range(2, 12));
            else exp_period = 8'(p);
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0;
                drive_cycle(div_in);
                drive_cycle(div_in);
                en = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                hold = $urandom_range(1, 30);
                for (int i = 0; i < hold; i++) drive_cycle(div_in);
            end
            drive_wave(h, p - h, $urandom_range(1, 6));
        end
        clr_rand = 1'b0;
        clr_err = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
